// File: rtl/a2d_pkg.sv
// Shared constants and types for the A2D SPI responder (ADC end of the SPI link).
package a2d_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned RES_W  = 12;
  localparam int unsigned CMD_W  = 16;
  localparam int unsigned CH_MSB = 13;
  localparam int unsigned CH_LSB = 11;
  localparam int unsigned CH_W   = CH_MSB - CH_LSB + 1;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic {IDLE, SHIFT} a2d_resp_state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer plus history flop for one SPI pin; edge pulses are
// registered so that level, rise and fall all carry the same delay.
module spi_edge_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= RST_VAL;
      sync  <= RST_VAL;
      level <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      meta  <= pin;
      sync  <= meta;
      level <= sync;
      rise  <= sync & ~level;
      fall  <= ~sync & level;
    end
  end

endmodule

// File: rtl/a2d_spi_responder.sv
// SPI slave ADC model: decodes a 16-bit channel command and returns the
// 12-bit result of the channel addressed by the previous frame, MSB first.
module a2d_spi_responder #(
  parameter int unsigned NUM_CH = a2d_pkg::NUM_CH,
  parameter int unsigned RES_W  = a2d_pkg::RES_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    SS_n,
  input  logic                    SCLK,
  input  logic                    MOSI,
  output logic                    MISO,
  input  logic [NUM_CH*RES_W-1:0] ch_data,
  output logic                    cmd_rcvd,
  output logic [15:0]             last_cmd,
  output logic [2:0]              chnnl_q,
  output logic                    frm_err
);

  import a2d_pkg::*;

  a2d_resp_state_t  state;
  logic [CMD_W-1:0] rx_shft;
  logic [CMD_W-1:0] tx_shft;
  logic [CNT_W-1:0] bit_cnt;

  logic ss_lvl, ss_rise, ss_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_edge_sync #(.RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst_n(rst_n), .pin(SS_n),
    .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );

  spi_edge_sync #(.RST_VAL(1'b1)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .pin(SCLK),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_edge_sync #(.RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst_n(rst_n), .pin(MOSI),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_sync = ^{ss_lvl, sclk_lvl, mosi_rise, mosi_fall};

  logic [RES_W-1:0] ch_sel;
  logic [CMD_W-1:0] tx_word;

  always_comb begin
    ch_sel = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      if (chnnl_q == CH_W'(n)) ch_sel = ch_data[n*RES_W +: RES_W];
    end
    tx_word = CMD_W'(ch_sel);
  end

  // Post-SCLK-edge view of rx/count, so an SS_n rise in the same clk
  // closes the frame on the already-updated values.
  logic [CMD_W-1:0] rx_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    rx_nxt  = rx_shft;
    cnt_nxt = bit_cnt;
    if (sclk_rise) begin
      rx_nxt = {rx_shft[CMD_W-2:0], mosi_lvl};
      if (bit_cnt != '1) cnt_nxt = bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rx_shft  <= '0;
      tx_shft  <= '0;
      bit_cnt  <= '0;
      cmd_rcvd <= 1'b0;
      frm_err  <= 1'b0;
      last_cmd <= '0;
      chnnl_q  <= '0;
    end else begin
      cmd_rcvd <= 1'b0;
      frm_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_fall) begin
            tx_shft <= tx_word;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          rx_shft <= rx_nxt;
          bit_cnt <= cnt_nxt;
          if (sclk_fall && bit_cnt != '0) tx_shft <= {tx_shft[CMD_W-2:0], 1'b0};
          if (ss_rise) begin
            if (cnt_nxt == CNT_W'(CMD_W)) begin
              last_cmd <= rx_nxt;
              chnnl_q  <= rx_nxt[CH_MSB:CH_LSB];
              cmd_rcvd <= 1'b1;
            end else begin
              frm_err  <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign MISO = (state == SHIFT) & tx_shft[CMD_W-1];

endmodule

// File: tb/tb_a2d_spi_responder.sv
// Directed bench for a2d_spi_responder: drives SPI frames with slow SCLK
// phases and checks returned words, pipelining, framing errors and reset.
module tb_a2d_spi_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SS_n, SCLK, MOSI;
  logic        MISO;
  logic [95:0] ch_data;
  logic        cmd_rcvd;
  logic [15:0] last_cmd;
  logic [2:0]  chnnl_q;
  logic        frm_err;

  int total = 0;
  int bad   = 0;
  int cmd_cnt = 0;
  int err_cnt = 0;

  a2d_spi_responder #(.NUM_CH(8), .RES_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .ch_data(ch_data), .cmd_rcvd(cmd_rcvd),
    .last_cmd(last_cmd), .chnnl_q(chnnl_q), .frm_err(frm_err)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (cmd_rcvd) cmd_cnt++;
    if (frm_err)  err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int idx, input logic [11:0] val);
    ch_data[idx*12 +: 12] = val;
  endtask

  task automatic send_bit(input logic b, output logic m);
    @(negedge clk);
    SCLK = 1'b0;
    MOSI = b;
    repeat (7) @(negedge clk);
    m = MISO;
    SCLK = 1'b1;
    repeat (7) @(negedge clk);
  endtask

  task automatic frame(input logic [15:0] cmd, input int nbits, input int chg_bit,
                       input int chg_ch, input logic [11:0] chg_val,
                       output logic [15:0] w, output int ncmd, output int nerr,
                       output int lat);
    int   c0, e0;
    logic m;
    c0 = cmd_cnt;
    e0 = err_cnt;
    w  = '0;
    @(negedge clk);
    SS_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      send_bit((i < 16) ? cmd[15-i] : 1'b0, m);
      if (i < 16) w[15-i] = m;
      if (i == chg_bit) set_ch(chg_ch, chg_val);
    end
    @(negedge clk);
    SS_n = 1'b1;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (cmd_rcvd && lat < 0) lat = k;
    end
    repeat (4) @(negedge clk);
    ncmd = cmd_cnt - c0;
    nerr = err_cnt - e0;
  endtask

  logic [15:0] w;
  logic [11:0] res;
  int          nc, ne, lat;
  logic        m;

  initial begin
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    ch_data = '0;
    set_ch(0, 12'h0A5);
    set_ch(3, 12'hC3C);
    set_ch(5, 12'h123);
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(MISO), 0);
    check("rst_cmd_rcvd", 32'(cmd_rcvd), 0);
    check("rst_last_cmd", 32'(last_cmd), 0);
    check("rst_chnnl_q", 32'(chnnl_q), 0);
    check("rst_frm_err", 32'(frm_err), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    frame(16'h1800, 16, -1, 0, 12'h0, w, nc, ne, lat);
    check("f1_word", 32'(w), 32'h00A5);
    check("f1_chnnl_q", 32'(chnnl_q), 3);
    check("f1_last_cmd", 32'(last_cmd), 32'h1800);
    check("f1_cmd_pulses", 32'(nc), 1);
    check("f1_latency", 32'(lat), 4);
    check("f1_frm_err", 32'(ne), 0);

    frame(16'h0000, 16, -1, 0, 12'h0, w, nc, ne, lat);
    check("f2_word", 32'(w), 32'h0C3C);
    check("f2_chnnl_q", 32'(chnnl_q), 0);

    frame(16'h2800, 16, -1, 0, 12'h0, w, nc, ne, lat);
    check("f3_word", 32'(w), 32'h00A5);
    frame(16'h2800, 16, -1, 0, 12'h0, w, nc, ne, lat);
    check("f4_word", 32'(w), 32'h0123);
    res = ~w[11:0];
    check("f4_inv_res", 32'(res), 32'hEDC);
    check("f4_chnnl_q", 32'(chnnl_q), 5);

    frame(16'h0800, 9, -1, 0, 12'h0, w, nc, ne, lat);
    check("short_frm_err", 32'(ne), 1);
    check("short_cmd_pulses", 32'(nc), 0);
    check("short_last_cmd", 32'(last_cmd), 32'h2800);
    check("short_chnnl_q", 32'(chnnl_q), 5);

    frame(16'h1800, 16, 4, 5, 12'hFFF, w, nc, ne, lat);
    check("chg_word", 32'(w), 32'h0123);
    check("chg_cmd_pulses", 32'(nc), 1);
    check("chg_chnnl_q", 32'(chnnl_q), 3);
    check("chg_last_cmd", 32'(last_cmd), 32'h1800);

    frame(16'h0000, 17, -1, 0, 12'h0, w, nc, ne, lat);
    check("long_word", 32'(w), 32'h0C3C);
    check("long_frm_err", 32'(ne), 1);
    check("long_cmd_pulses", 32'(nc), 0);
    check("long_chnnl_q", 32'(chnnl_q), 3);

    // Mid-frame reset: chnnl_q is 3 going in, so a clear is observable.
    @(negedge clk);
    SS_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) send_bit(1'b1, m);
    check("mid_pre_chnnl_q", 32'(chnnl_q), 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_miso", 32'(MISO), 0);
    check("mid_rst_chnnl_q", 32'(chnnl_q), 0);
    check("mid_rst_last_cmd", 32'(last_cmd), 0);
    SS_n = 1'b1;
    SCLK = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    frame(16'h0000, 16, -1, 0, 12'h0, w, nc, ne, lat);
    check("post_rst_word", 32'(w), 32'h00A5);
    check("post_rst_cmd_pulses", 32'(nc), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
